// File: rtl/mc_controller_pkg.sv
// Shared types and encodings for the multicycle RV32I controller.
// State order fixes the state_dbg encoding seen by debug tooling.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADR   = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WRITE = 4'd4,
        S_MEM_WB    = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_JALR      = 4'd11,
        S_JAL_LINK  = 4'd12,
        S_LUI       = 4'd13,
        S_AUIPC     = 4'd14,
        S_HALT      = 4'd15
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;

    typedef enum logic [1:0] {
        OPC_ADD = 2'd0,
        OPC_R   = 2'd1,
        OPC_I   = 2'd2,
        OPC_BR  = 2'd3
    } op_class_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] RES_ALU_REG = 2'b00;
    localparam logic [1:0] RES_MEM     = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_OLD_PC = 2'b01;
    localparam logic [1:0] SRCA_RD1    = 2'b10;
    localparam logic [1:0] SRCA_ZERO   = 2'b11;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// Combinational funct decode: ALU operation per op class plus an illegal-funct flag.
module alu_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  op_class_t  op_class,
    output alu_op_t    alu_control,
    output logic       illegal_funct
);

    always_comb begin
        alu_control   = ALU_ADD;
        illegal_funct = 1'b0;
        case (op_class)
            OPC_R, OPC_I: begin
                case (funct3)
                    3'b000: alu_control = (op_class == OPC_R && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001: alu_control = ALU_SLL;
                    3'b010: alu_control = ALU_SLT;
                    3'b011: alu_control = ALU_SLTU;
                    3'b100: alu_control = ALU_XOR;
                    3'b101: alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110: alu_control = ALU_OR;
                    default: alu_control = ALU_AND;
                endcase
                // funct7[5] is only meaningful for SUB/SRA (R) and SRAI (I); for other
                // I-type ops that bit belongs to the immediate.
                if (op_class == OPC_R && funct7b5 && funct3 != 3'b000 && funct3 != 3'b101)
                    illegal_funct = 1'b1;
                if (op_class == OPC_I && funct7b5 && funct3 == 3'b001)
                    illegal_funct = 1'b1;
            end
            OPC_BR: begin
                alu_control   = ALU_SUB;
                illegal_funct = (funct3[2:1] == 2'b01);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RV32I control FSM with memory wait states, full branch set and sticky trap.
// Outputs are decoded from the state register; FETCH completion and BRANCH pc_write are Mealy.
module mc_controller
    import rv_ctrl_pkg::*;
#(
    parameter bit          MEM_HANDSHAKE   = 1'b1,
    parameter int unsigned FIXED_LAT       = 1,
    parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        carry,
    input  logic        sign,
    input  logic        overflow,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        adr_src,
    output logic        mem_write,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [1:0]  result_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  imm_src,
    output logic [3:0]  alu_control,
    output logic        illegal,
    output logic [3:0]  state_dbg
);

    localparam logic [3:0] LAT_LAST  = 4'(FIXED_LAT - 1);
    localparam state_t     ILL_STATE = TRAP_ON_ILLEGAL ? S_HALT : S_FETCH;

    state_t     state, state_next;
    logic [3:0] wait_cnt;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       mem_done, taken, lt, illegal_funct;
    op_class_t  op_class;
    alu_op_t    dec_alu;
    logic       unused_instr_bits;

    assign opcode            = instr[6:0];
    assign funct3            = instr[14:12];
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};
    assign mem_done          = MEM_HANDSHAKE ? mem_ready : (wait_cnt == LAT_LAST);
    assign lt                = sign ^ overflow;
    assign state_dbg         = state;

    always_comb begin
        case (opcode)
            OP_R:      op_class = OPC_R;
            OP_I:      op_class = OPC_I;
            OP_BRANCH: op_class = OPC_BR;
            default:   op_class = OPC_ADD;
        endcase
    end

    alu_decoder u_alu_decoder (
        .funct3        (funct3),
        .funct7b5      (instr[30]),
        .op_class      (op_class),
        .alu_control   (dec_alu),
        .illegal_funct (illegal_funct)
    );

    // carry=1 means the subtraction did not borrow, i.e. rd1 >= rd2 unsigned
    always_comb begin
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            3'b110:  taken = !carry;
            3'b111:  taken = carry;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:     if (mem_done) state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEM_ADR;
                    OP_R:              state_next = S_EXEC_R;
                    OP_I:              state_next = S_EXEC_I;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_JALR:           state_next = S_JALR;
                    OP_LUI:            state_next = S_LUI;
                    OP_AUIPC:          state_next = S_AUIPC;
                    default:           state_next = ILL_STATE;
                endcase
                if (illegal_funct) state_next = ILL_STATE;
            end
            S_MEM_ADR:   state_next = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (mem_done) state_next = S_MEM_WB;
            S_MEM_WRITE: if (mem_done) state_next = S_FETCH;
            S_MEM_WB, S_ALU_WB, S_BRANCH: state_next = S_FETCH;
            S_EXEC_R, S_EXEC_I, S_JAL, S_JAL_LINK, S_LUI, S_AUIPC: state_next = S_ALU_WB;
            S_JALR:      state_next = S_JAL_LINK;
            S_HALT:      state_next = S_HALT;
            default:     state_next = S_FETCH;
        endcase
    end

    // Wait counter restarts on every state change and saturates instead of wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if (state_next != state)
                wait_cnt <= '0;
            else if (wait_cnt != LAT_LAST)
                wait_cnt <= wait_cnt + 4'd1;
        end
    end

    always_comb begin
        mem_req     = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        result_src  = RES_ALU_REG;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RD2;
        imm_src     = IMM_I;
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                ir_write   = mem_done;
                pc_write   = mem_done;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLD_PC;
                alu_src_b = SRCB_IMM;
                imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
            end
            S_MEM_ADR: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
            end
            S_MEM_READ: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_req   = 1'b1;
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_MEM_WB: begin
                result_src = RES_MEM;
                reg_write  = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a   = SRCA_RD1;
                alu_control = dec_alu;
            end
            S_EXEC_I: begin
                alu_src_a   = SRCA_RD1;
                alu_src_b   = SRCB_IMM;
                alu_control = dec_alu;
            end
            S_ALU_WB: reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a   = SRCA_RD1;
                alu_control = ALU_SUB;
                pc_write    = taken;
            end
            S_JAL: begin
                alu_src_a = SRCA_OLD_PC;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
            end
            S_JALR: begin
                alu_src_a  = SRCA_RD1;
                alu_src_b  = SRCB_IMM;
                result_src = RES_ALU;
                pc_write   = 1'b1;
            end
            S_JAL_LINK: begin
                alu_src_a = SRCA_OLD_PC;
                alu_src_b = SRCB_FOUR;
            end
            S_LUI: begin
                alu_src_a = SRCA_ZERO;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_U;
            end
            S_AUIPC: begin
                alu_src_a = SRCA_OLD_PC;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_U;
            end
            S_HALT:  illegal = 1'b1;
            default: ;
        endcase
        // Reset overrides everything, including a coincident mem_ready completion
        if (reset) begin
            mem_req     = 1'b0;
            adr_src     = 1'b0;
            mem_write   = 1'b0;
            ir_write    = 1'b0;
            pc_write    = 1'b0;
            reg_write   = 1'b0;
            result_src  = 2'b00;
            alu_src_a   = 2'b00;
            alu_src_b   = 2'b00;
            imm_src     = 3'b000;
            alu_control = 4'd0;
            illegal     = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: per-instruction expectations derived from ISA-level timing rules.
module tb_mc_controller;
    import rv_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        zero = 1'b0, carry = 1'b0, sign = 1'b0, overflow = 1'b0;
    logic        mem_ready = 1'b0;

    logic       m_mem_req, m_adr_src, m_mem_write, m_ir_write, m_pc_write, m_reg_write, m_illegal;
    logic [1:0] m_result_src, m_alu_src_a, m_alu_src_b;
    logic [2:0] m_imm_src;
    logic [3:0] m_alu_control, m_state_dbg;
    logic       f_mem_req, f_adr_src, f_mem_write, f_ir_write, f_pc_write, f_reg_write, f_illegal;
    logic [1:0] f_result_src, f_alu_src_a, f_alu_src_b;
    logic [2:0] f_imm_src;
    logic [3:0] f_alu_control, f_state_dbg;
    logic       unused_f;

    bit  sel_f = 1'b0;
    bit  at_neg = 1'b0;
    int  checks = 0;
    int  errors = 0;

    logic       o_mem_req, o_adr_src, o_mem_write, o_ir_write, o_pc_write, o_reg_write, o_illegal;
    logic [1:0] o_result_src;
    logic [3:0] o_alu_control, o_state_dbg;

    assign o_mem_req     = sel_f ? f_mem_req     : m_mem_req;
    assign o_adr_src     = sel_f ? f_adr_src     : m_adr_src;
    assign o_mem_write   = sel_f ? f_mem_write   : m_mem_write;
    assign o_ir_write    = sel_f ? f_ir_write    : m_ir_write;
    assign o_pc_write    = sel_f ? f_pc_write    : m_pc_write;
    assign o_reg_write   = sel_f ? f_reg_write   : m_reg_write;
    assign o_illegal     = sel_f ? f_illegal     : m_illegal;
    assign o_result_src  = sel_f ? f_result_src  : m_result_src;
    assign o_alu_control = sel_f ? f_alu_control : m_alu_control;
    assign o_state_dbg   = sel_f ? f_state_dbg   : m_state_dbg;
    assign unused_f      = ^{f_alu_src_a, f_alu_src_b, f_imm_src};

    always #5 clk = ~clk;

    mc_controller dut (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero), .carry(carry), .sign(sign),
        .overflow(overflow), .mem_ready(mem_ready), .mem_req(m_mem_req), .adr_src(m_adr_src),
        .mem_write(m_mem_write), .ir_write(m_ir_write), .pc_write(m_pc_write),
        .reg_write(m_reg_write), .result_src(m_result_src), .alu_src_a(m_alu_src_a),
        .alu_src_b(m_alu_src_b), .imm_src(m_imm_src), .alu_control(m_alu_control),
        .illegal(m_illegal), .state_dbg(m_state_dbg)
    );

    mc_controller #(.MEM_HANDSHAKE(1'b0), .FIXED_LAT(3), .TRAP_ON_ILLEGAL(1'b0)) dut_f (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero), .carry(carry), .sign(sign),
        .overflow(overflow), .mem_ready(mem_ready), .mem_req(f_mem_req), .adr_src(f_adr_src),
        .mem_write(f_mem_write), .ir_write(f_ir_write), .pc_write(f_pc_write),
        .reg_write(f_reg_write), .result_src(f_result_src), .alu_src_a(f_alu_src_a),
        .alu_src_b(f_alu_src_b), .imm_src(f_imm_src), .alu_control(f_alu_control),
        .illegal(f_illegal), .state_dbg(f_state_dbg)
    );

    // RV32I OP/OP-IMM funct3 to ALU operation code
    function automatic logic [3:0] exp_ri_op(input logic [2:0] f3, input logic f7b5, input logic is_r);
        case (f3)
            3'd0:    return (is_r && f7b5) ? 4'd1 : 4'd0;
            3'd1:    return 4'd5;
            3'd2:    return 4'd8;
            3'd3:    return 4'd9;
            3'd4:    return 4'd4;
            3'd5:    return f7b5 ? 4'd7 : 4'd6;
            3'd6:    return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [2:0]  f3;
        int          k;
        r  = $urandom();
        k  = $urandom_range(0, 8);
        f3 = r[14:12];
        case (k)
            0: begin r[6:0] = 7'b0110011; r[31:25] = ((f3 == 3'd0 || f3 == 3'd5) && r[30]) ? 7'h20 : 7'h00; end
            1: begin
                r[6:0] = 7'b0010011;
                if (f3 == 3'd1) r[31:25] = 7'h00;
                else if (f3 == 3'd5) r[31:25] = r[30] ? 7'h20 : 7'h00;
            end
            2: r[6:0] = 7'b0000011;
            3: r[6:0] = 7'b0100011;
            4: begin r[6:0] = 7'b1100011; if (f3[2:1] == 2'b01) r[14] = 1'b1; end
            5: r[6:0] = 7'b1101111;
            6: begin r[6:0] = 7'b1100111; r[14:12] = 3'd0; end
            7: r[6:0] = 7'b0110111;
            default: r[6:0] = 7'b0010111;
        endcase
        return r;
    endfunction

    task automatic do_reset();
        reset     = 1'b1;
        mem_ready = 1'($urandom_range(0, 1));
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset  = 1'b0;
        at_neg = 1'b1;
    endtask

    // Runs one instruction from its first FETCH cycle until the next FETCH begins.
    task automatic run_instr(input logic [31:0] ins, input logic [3:0] flags,
                             input int wf_in, input int wm_in, input string name);
        logic [6:0] opc;
        logic [2:0] f3;
        logic       z, c, s, o, taken, is_mem, is_store, chk_alu, done, ir_seen, pcw_at_ir;
        logic [3:0] exp_alu, alu_at;
        logic [1:0] exp_res, res_at;
        int wf, wm, base, exp_cyc, exp_pcw, exp_rw, exp_mw, exp_adr;
        int cyc, acc, cnt, ir_n, ir_cyc, pcw_n, rw_n, rw_cyc, mw_n, adr_n, ill_n;
        opc = ins[6:0];
        f3  = ins[14:12];
        {z, c, s, o} = flags;
        wf = sel_f ? 2 : wf_in;
        wm = sel_f ? 2 : wm_in;
        base = 2; is_mem = 0; is_store = 0; chk_alu = 1; taken = 0;
        exp_alu = 4'd0; exp_rw = 1; exp_res = 2'b00; exp_pcw = 1;
        case (opc)
            7'b0110011: begin base = 4; exp_alu = exp_ri_op(f3, ins[30], 1'b1); end
            7'b0010011: begin base = 4; exp_alu = exp_ri_op(f3, ins[30], 1'b0); end
            7'b0000011: begin base = 5; is_mem = 1; exp_res = 2'b01; end
            7'b0100011: begin base = 4; is_mem = 1; is_store = 1; exp_rw = 0; end
            7'b1100011: begin
                base = 3; exp_rw = 0; exp_alu = 4'd1;
                case (f3)
                    3'd0: taken = z;
                    3'd1: taken = !z;
                    3'd4: taken = (s != o);
                    3'd5: taken = (s == o);
                    3'd6: taken = !c;
                    default: taken = c;
                endcase
                exp_pcw = taken ? 2 : 1;
            end
            7'b1101111: begin base = 4; exp_pcw = 2; end
            7'b1100111: begin base = 5; exp_pcw = 2; end
            7'b0110111, 7'b0010111: base = 4;
            default: begin base = 2; exp_rw = 0; chk_alu = 0; end
        endcase
        exp_cyc = base + wf + (is_mem ? wm : 0);
        exp_mw  = is_store ? wm + 1 : 0;
        exp_adr = is_mem ? wm + 1 : 0;

        instr = ins;
        {zero, carry, sign, overflow} = flags;
        cyc = 0; acc = 0; cnt = 0; ir_n = 0; ir_cyc = -1; pcw_n = 0; rw_n = 0; rw_cyc = -1;
        mw_n = 0; adr_n = 0; ill_n = 0; done = 0; ir_seen = 0; pcw_at_ir = 0;
        alu_at = 4'hF; res_at = 2'b11;
        while (!done && cyc < 80) begin
            if (!at_neg) @(negedge clk);
            at_neg = 1'b0;
            if (ir_seen && o_state_dbg == S_FETCH) begin
                done   = 1'b1;
                at_neg = 1'b1;
            end else begin
                if (!sel_f && o_mem_req) mem_ready = (cnt == ((acc == 0) ? wf : wm));
                else mem_ready = 1'($urandom_range(0, 1));
                #1;
                if (o_ir_write) begin ir_n++; ir_cyc = cyc; ir_seen = 1'b1; pcw_at_ir = o_pc_write; end
                if (o_pc_write) pcw_n++;
                if (o_reg_write) begin rw_n++; rw_cyc = cyc; res_at = o_result_src; end
                if (o_mem_write) mw_n++;
                if (o_adr_src) adr_n++;
                if (o_illegal) ill_n++;
                if (ir_seen && cyc == ir_cyc + 2) alu_at = o_alu_control;
                if (o_mem_req) begin
                    if (!sel_f && mem_ready) begin acc++; cnt = 0; end
                    else cnt++;
                end
                cyc++;
            end
        end

        checks++; if (!done) begin errors++; $display("FAIL %s timeout cycles=%0d budget=80", name, cyc); end
        checks++; if (cyc !== exp_cyc) begin errors++; $display("FAIL %s cycles got %0d want %0d", name, cyc, exp_cyc); end
        checks++; if (ir_n !== 1 || ir_cyc !== wf) begin errors++; $display("FAIL %s ir_write count %0d at %0d want 1 at %0d", name, ir_n, ir_cyc, wf); end
        checks++; if (pcw_at_ir !== 1'b1) begin errors++; $display("FAIL %s pc_write with ir_write got %0b want 1", name, pcw_at_ir); end
        checks++; if (pcw_n !== exp_pcw) begin errors++; $display("FAIL %s pc_write count got %0d want %0d", name, pcw_n, exp_pcw); end
        checks++; if (rw_n !== exp_rw) begin errors++; $display("FAIL %s reg_write count got %0d want %0d", name, rw_n, exp_rw); end
        if (exp_rw == 1) begin
            checks++; if (rw_cyc !== exp_cyc - 1) begin errors++; $display("FAIL %s reg_write cycle got %0d want %0d", name, rw_cyc, exp_cyc - 1); end
            checks++; if (res_at !== exp_res) begin errors++; $display("FAIL %s wb result_src got %0d want %0d", name, res_at, exp_res); end
        end
        checks++; if (mw_n !== exp_mw) begin errors++; $display("FAIL %s mem_write cycles got %0d want %0d", name, mw_n, exp_mw); end
        checks++; if (adr_n !== exp_adr) begin errors++; $display("FAIL %s adr_src cycles got %0d want %0d", name, adr_n, exp_adr); end
        checks++; if (ill_n !== 0) begin errors++; $display("FAIL %s illegal cycles got %0d want 0", name, ill_n); end
        if (chk_alu) begin
            checks++; if (alu_at !== exp_alu) begin errors++; $display("FAIL %s alu_control got %0d want %0d", name, alu_at, exp_alu); end
        end
    endtask

    task automatic test_reset();
        sel_f = 1'b0;
        reset = 1'b1;
        mem_ready = 1'b1;
        instr = 32'h002081B3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (m_state_dbg !== S_FETCH) begin errors++; $display("FAIL reset state got %0d want %0d", m_state_dbg, S_FETCH); end
        checks++; if ({m_mem_req, m_adr_src, m_mem_write, m_ir_write, m_pc_write, m_reg_write} !== 6'b0) begin
            errors++; $display("FAIL reset strobes got %b want 000000", {m_mem_req, m_adr_src, m_mem_write, m_ir_write, m_pc_write, m_reg_write}); end
        checks++; if ({m_result_src, m_alu_src_a, m_alu_src_b, m_imm_src, m_alu_control} !== 13'b0) begin
            errors++; $display("FAIL reset selects got %h want 0", {m_result_src, m_alu_src_a, m_alu_src_b, m_imm_src, m_alu_control}); end
        checks++; if (m_illegal !== 1'b0) begin errors++; $display("FAIL reset illegal got %b want 0", m_illegal); end
        reset = 1'b0;
        #1;
        checks++; if (m_mem_req !== 1'b1 || m_adr_src !== 1'b0) begin errors++; $display("FAIL first_fetch mem_req/adr_src got %b%b want 10", m_mem_req, m_adr_src); end
        checks++; if (m_alu_src_a !== 2'b00 || m_alu_src_b !== 2'b10 || m_result_src !== 2'b10) begin
            errors++; $display("FAIL first_fetch selects a=%0d b=%0d res=%0d want 0 2 2", m_alu_src_a, m_alu_src_b, m_result_src); end
        at_neg = 1'b1;
    endtask

    task automatic test_add();
        run_instr(32'h002081B3, 4'b0000, 0, 0, "add");
    endtask

    task automatic test_load_wait();
        run_instr(32'h0040A283, 4'b0000, 0, 2, "lw_wait");
        run_instr(32'h0050A223, 4'b0000, 1, 1, "sw_wait");
    endtask

    task automatic test_branch();
        run_instr(32'h0020C463, 4'b0010, 0, 0, "blt_taken");
        run_instr(32'h0020C463, 4'b0011, 0, 0, "blt_not_taken");
        run_instr(32'h0020E463, 4'b0000, 0, 0, "bltu_borrow");
        run_instr(32'h0020F463, 4'b0000, 0, 0, "bgeu_borrow");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++)
            run_instr(rand_instr(), 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3), "random");
    endtask

    task automatic test_illegal();
        sel_f = 1'b0;
        do_reset();
        instr = 32'h0000007F;
        for (int i = 0; i < 22; i++) begin
            if (!at_neg) @(negedge clk);
            at_neg = 1'b0;
            mem_ready = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            if (i == 2) begin
                checks++; if (o_state_dbg !== S_HALT) begin errors++; $display("FAIL halt state got %0d want %0d", o_state_dbg, S_HALT); end
            end
            if (i >= 2) begin
                checks++; if (o_illegal !== 1'b1) begin errors++; $display("FAIL halt illegal cycle %0d got %b want 1", i, o_illegal); end
                checks++; if ({o_mem_req, o_adr_src, o_mem_write, o_ir_write, o_pc_write, o_reg_write} !== 6'b0) begin
                    errors++; $display("FAIL halt strobes cycle %0d got %b want 000000", i, {o_mem_req, o_adr_src, o_mem_write, o_ir_write, o_pc_write, o_reg_write}); end
            end
        end
        do_reset();
        #1;
        checks++; if (o_illegal !== 1'b0 || o_state_dbg !== S_FETCH) begin
            errors++; $display("FAIL halt_exit illegal=%b state=%0d want 0 %0d", o_illegal, o_state_dbg, S_FETCH); end
        run_instr(32'h002081B3, 4'b0000, 0, 0, "add_after_halt");
    endtask

    task automatic test_fixed_lat();
        sel_f = 1'b1;
        do_reset();
        run_instr(32'h0050A223, 4'b0000, 0, 0, "sw_fixed");
        run_instr(32'h0040A283, 4'b0000, 0, 0, "lw_fixed");
        run_instr(32'h002081B3, 4'b0000, 0, 0, "add_fixed");
        run_instr(32'h0000007F, 4'b0000, 0, 0, "illegal_nop");
        run_instr(32'h123452B7, 4'b0000, 0, 0, "lui_fixed");
        sel_f = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        int  rw_seen, rd_cyc;
        logic fired;
        sel_f = 1'b0;
        do_reset();
        instr = 32'h0040A283;
        {zero, carry, sign, overflow} = 4'b0000;
        rw_seen = 0; rd_cyc = 0; fired = 1'b0;
        for (int i = 0; i < 30 && !fired; i++) begin
            if (!at_neg) @(negedge clk);
            at_neg = 1'b0;
            mem_ready = o_adr_src ? 1'b0 : 1'b1;
            #1;
            if (o_reg_write) rw_seen++;
            if (o_adr_src) rd_cyc++;
            if (rd_cyc == 2) fired = 1'b1;
        end
        checks++; if (fired !== 1'b1) begin errors++; $display("FAIL mid_read reached got %b want 1", fired); end
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'b1;
        #1;
        checks++; if ({o_mem_req, o_reg_write, o_pc_write, o_ir_write} !== 4'b0) begin
            errors++; $display("FAIL reset_with_ready strobes got %b want 0000", {o_mem_req, o_reg_write, o_pc_write, o_ir_write}); end
        @(negedge clk);
        #1;
        checks++; if (o_state_dbg !== S_FETCH || o_reg_write !== 1'b0) begin
            errors++; $display("FAIL mid_read_reset state=%0d reg_write=%b want %0d 0", o_state_dbg, o_reg_write, S_FETCH); end
        checks++; if (rw_seen !== 0) begin errors++; $display("FAIL mid_read reg_write count got %0d want 0", rw_seen); end
        @(negedge clk);
        reset = 1'b0;
        at_neg = 1'b1;
        run_instr(32'h002081B3, 4'b0000, 0, 0, "add_after_abort");
    endtask

    initial begin
        test_reset();
        test_add();
        test_load_wait();
        test_branch();
        test_random();
        test_illegal();
        test_fixed_lat();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
